// File: rtl/event_dispatcher.sv
// Transmit end of the queue->core path: pops the queue head and hands each event
// to the first free core at or above a round-robin pointer, tracking the busy cores.
module event_dispatcher #(
  parameter int unsigned NUM_CORE = 4,
  parameter int unsigned MSG_WID  = 32,
  parameter int unsigned TIME_WID = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        q_vld,
  input  logic [MSG_WID-1:0]          q_msg,
  output logic                        q_deq,
  input  logic                        halt,
  input  logic [NUM_CORE-1:0]         core_done,
  output logic [NUM_CORE-1:0]         core_active,
  output logic                        sent_msg_vld,
  output logic [$clog2(NUM_CORE)-1:0] core_id,
  output logic [MSG_WID-1:0]          sent_msg,
  output logic [NUM_CORE-1:0]         core_load,
  output logic [31:0]                 dispatch_cnt,
  output logic                        done_err
);

  localparam int unsigned IDW = $clog2(NUM_CORE);
  localparam int unsigned CW  = 32;

  if ((NUM_CORE < 2) || ((NUM_CORE & (NUM_CORE - 1)) != 0)) begin : g_bad_num_core
    $error("event_dispatcher: NUM_CORE must be a power of 2 and >= 2");
  end
  if ((TIME_WID == 0) || (TIME_WID > MSG_WID)) begin : g_bad_time_wid
    $error("event_dispatcher: TIME_WID must fit inside MSG_WID");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]      id_q, id_d;
  logic [MSG_WID-1:0]  msg_q, msg_d;
  logic [NUM_CORE-1:0] active_q, active_d;
  logic [NUM_CORE-1:0] load_q, load_d;
  logic                vld_q, vld_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q, err_d;

  logic [NUM_CORE-1:0] free;
  logic [IDW-1:0]      pick;
  logic                pick_vld;
  logic [IDW-1:0]      idx;

  // Round-robin search: first free core at or above rr_ptr, wrapping.
  always_comb begin
    free     = ~active_q;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < NUM_CORE; k++) begin
      idx = rr_ptr_q + IDW'(k);
      if (!pick_vld && free[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  // Next-state and pop strobe; a set for the core being loaded beats a clear.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    msg_d    = msg_q;
    load_d   = '0;
    vld_d    = 1'b0;
    cnt_d    = cnt_q;
    active_d = active_q & ~core_done;
    err_d    = err_q | (|(core_done & ~active_q));
    q_deq    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (q_vld && !halt && pick_vld && !reset) begin
          q_deq   = 1'b1;
          id_d    = pick;
          msg_d   = q_msg;
          vld_d   = 1'b1;
          load_d  = NUM_CORE'(1) << pick;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        active_d[id_q] = 1'b1;
        rr_ptr_d       = id_q + IDW'(1);
        cnt_d          = cnt_q + CW'(1);
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      msg_q    <= '0;
      load_q   <= '0;
      vld_q    <= 1'b0;
      cnt_q    <= '0;
      active_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      msg_q    <= msg_d;
      load_q   <= load_d;
      vld_q    <= vld_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      err_q    <= err_d;
    end
  end

  assign core_active  = active_q;
  assign sent_msg_vld = vld_q;
  assign core_id      = id_q;
  assign sent_msg     = msg_q;
  assign core_load    = load_q;
  assign dispatch_cnt = cnt_q;
  assign done_err     = err_q;

endmodule
